// File: rtl/periph_bus_arb.sv
// rtl/periph_bus_arb.sv - two-master round-robin arbiter and access sequencer for the peripheral register bus
module periph_bus_arb #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_data_i,
    output logic          m0_gnt_o,
    output logic          m0_ack_o,
    output logic [DW-1:0] m0_data_o,
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_data_i,
    output logic          m1_gnt_o,
    output logic          m1_ack_o,
    output logic [DW-1:0] m1_data_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_addr_o,
    output logic [DW-1:0] s_data_o,
    input  logic [DW-1:0] s_data_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          owner, owner_nxt;    // 0 = master 0, 1 = master 1
    logic          last, last_nxt;      // most recently granted master
    logic [1:0]    gnt, gnt_nxt;        // bit m = master m granted
    logic [1:0]    ack, ack_nxt;
    logic [DW-1:0] m0_q, m1_q;

    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    // State, pointer and registered grant/ack flops
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            gnt   <= 2'b00;
            ack   <= 2'b00;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
            gnt   <= gnt_nxt;
            ack   <= ack_nxt;
        end
    end

    // Next-state: arbitrate only in IDLE, then walk ACCESS -> ACK -> IDLE
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        gnt_nxt   = 2'b00;
        ack_nxt   = 2'b00;
        case (state)
            IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    // On a tie the master that did not go last wins
                    if (m0_req_i && m1_req_i) begin
                        owner_nxt = ~last;
                    end else begin
                        owner_nxt = m1_req_i;
                    end
                    last_nxt  = owner_nxt;
                    state_nxt = ACCESS;
                    gnt_nxt   = owner_nxt ? 2'b10 : 2'b01;
                end
            end
            ACCESS: begin
                state_nxt = ACK;
                ack_nxt   = owner ? 2'b10 : 2'b01;
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Owner's transaction fields, selected ahead of the state gate
    always_comb begin
        sel_we   = m0_we_i;
        sel_addr = m0_addr_i;
        sel_data = m0_data_i;
        if (owner) begin
            sel_we   = m1_we_i;
            sel_addr = m1_addr_i;
            sel_data = m1_data_i;
        end
    end

    // Slave bus is live only during ACCESS so each write strobes exactly once
    always_comb begin
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_data_o = '0;
        if (state == ACCESS) begin
            s_we_o   = sel_we;
            s_addr_o = sel_addr;
            s_data_o = sel_data;
        end
    end

    // Read data is captured at the end of ACCESS and held until the next read
    always_ff @(posedge clk) begin
        if (!rst) begin
            m0_q <= '0;
            m1_q <= '0;
        end else if (state == ACCESS && !sel_we) begin
            if (owner) begin
                m1_q <= s_data_i;
            end else begin
                m0_q <= s_data_i;
            end
        end
    end

    assign m0_gnt_o  = gnt[0];
    assign m1_gnt_o  = gnt[1];
    assign m0_ack_o  = ack[0];
    assign m1_ack_o  = ack[1];
    assign m0_data_o = m0_q;
    assign m1_data_o = m1_q;

endmodule

// File: tb/tb_periph_bus_arb.sv
// tb/tb_periph_bus_arb.sv - self-checking bench for periph_bus_arb
module tb_periph_bus_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr [2];
    logic [31:0] wdat [2];

    logic        m0_gnt_o, m0_ack_o, m1_gnt_o, m1_ack_o;
    logic [31:0] m0_data_o, m1_data_o;
    logic        s_we_o;
    logic [31:0] s_addr_o, s_data_o, s_data_i;

    logic [31:0] mem [16];

    int checks = 0;
    int errors = 0;

    // Reference model: transaction phase counter (0 idle, 1 access, 2 ack)
    int          age;
    logic        own;
    logic        mlast;
    logic [31:0] mq   [2];
    logic [31:0] mmem [16];
    bit          mcheck;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [31:0] a0, d0, a1, d1;
        logic [1:0]  gnt, ack;
        logic        swe;
        logic [31:0] saddr, sdata, q0, q1;
    } vec_t;
    vec_t tbl [14];

    always #5 clk = ~clk;

    periph_bus_arb #(.AW(32), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req_i  (req[0]),
        .m0_we_i   (we[0]),
        .m0_addr_i (addr[0]),
        .m0_data_i (wdat[0]),
        .m0_gnt_o  (m0_gnt_o),
        .m0_ack_o  (m0_ack_o),
        .m0_data_o (m0_data_o),
        .m1_req_i  (req[1]),
        .m1_we_i   (we[1]),
        .m1_addr_i (addr[1]),
        .m1_data_i (wdat[1]),
        .m1_gnt_o  (m1_gnt_o),
        .m1_ack_o  (m1_ack_o),
        .m1_data_o (m1_data_o),
        .s_we_o    (s_we_o),
        .s_addr_o  (s_addr_o),
        .s_data_o  (s_data_o),
        .s_data_i  (s_data_i)
    );

    // GPIO-like slave: 16 word registers, combinational read
    assign s_data_i = mem[s_addr_o[5:2]];
    always @(posedge clk) begin
        if (s_we_o) mem[s_addr_o[5:2]] <= s_data_o;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic [1:0] r, input logic [1:0] w, input logic [31:0] a0,
                       input logic [31:0] d0, input logic [31:0] a1, input logic [31:0] d1);
        req = r; we = w; addr[0] = a0; wdat[0] = d0; addr[1] = a1; wdat[1] = d1;
    endtask

    task automatic setv(input int i, input logic [1:0] r, input logic [1:0] w,
                        input logic [31:0] a0, input logic [31:0] d0,
                        input logic [31:0] a1, input logic [31:0] d1,
                        input logic [1:0] g, input logic [1:0] k, input logic swe,
                        input logic [31:0] sa, input logic [31:0] sd,
                        input logic [31:0] q0, input logic [31:0] q1);
        tbl[i].req = r; tbl[i].we = w; tbl[i].a0 = a0; tbl[i].d0 = d0;
        tbl[i].a1 = a1; tbl[i].d1 = d1; tbl[i].gnt = g; tbl[i].ack = k;
        tbl[i].swe = swe; tbl[i].saddr = sa; tbl[i].sdata = sd;
        tbl[i].q0 = q0; tbl[i].q1 = q1;
    endtask

    task automatic model_check();
        logic [1:0]  eg, ek;
        logic        ewe;
        logic [31:0] ea, ed;
        eg = 2'b00; ek = 2'b00; ewe = 1'b0; ea = '0; ed = '0;
        if (age == 1) begin
            eg  = own ? 2'b10 : 2'b01;
            ewe = we[own];
            ea  = addr[own];
            ed  = wdat[own];
        end
        if (age == 2) ek = own ? 2'b10 : 2'b01;
        chk("model gnt", {30'd0, m1_gnt_o, m0_gnt_o}, {30'd0, eg});
        chk("model ack", {30'd0, m1_ack_o, m0_ack_o}, {30'd0, ek});
        chk("model s_we", {31'd0, s_we_o}, {31'd0, ewe});
        chk("model s_addr", s_addr_o, ea);
        chk("model s_data", s_data_o, ed);
        chk("model m0_data", m0_data_o, mq[0]);
        chk("model m1_data", m1_data_o, mq[1]);
    endtask

    task automatic model_update();
        logic [31:0] a;
        a = addr[own];
        if (!rst) begin
            // a write strobed during an aborted ACCESS still lands in the slave
            if (age == 1 && we[own]) mmem[a[5:2]] = wdat[own];
            age = 0; mlast = 1'b1; mq[0] = '0; mq[1] = '0;
        end else if (age == 0) begin
            if (req != 2'b00) begin
                own   = (req == 2'b11) ? ~mlast : req[1];
                mlast = own;
                age   = 1;
            end
        end else if (age == 1) begin
            if (we[own]) mmem[a[5:2]] = wdat[own];
            else         mq[own] = mmem[a[5:2]];
            age = 2;
        end else begin
            age = 0;
        end
    endtask

    task automatic end_cycle();
        if (mcheck) model_check();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic new_txn(input int m);
        req[m]  = 1'b1;
        we[m]   = 1'($urandom_range(0, 1));
        addr[m] = 32'($urandom_range(0, 15)) << 2;
        wdat[m] = $urandom;
    endtask

    initial begin
        logic [31:0] a0v, d0v;
        bit   exp_we  [6];
        bit   exp_ack [6];
        int   gq [$];
        int   rr_exp [4];

        for (int i = 0; i < 16; i++) begin
            mem[i]  = 32'hA5A5_0001 + (32'(i) << 8);
            mmem[i] = 32'hA5A5_0001 + (32'(i) << 8);
        end
        rst = 1'b0;
        drv(2'b00, 2'b00, 0, 0, 0, 0);
        mcheck = 1'b0;
        age = 0; own = 1'b0; mlast = 1'b1; mq[0] = '0; mq[1] = '0;

        //     i  req    we     a0  d0     a1  d1      gnt    ack    swe  saddr sdata  q0  q1
        setv(0,  2'b00, 2'b00, 0,  0,     0,  0,      2'b00, 2'b00, 0,   0,    0,     0,  0);
        setv(1,  2'b01, 2'b01, 4,  3,     0,  0,      2'b00, 2'b00, 0,   0,    0,     0,  0);
        setv(2,  2'b01, 2'b01, 4,  3,     0,  0,      2'b01, 2'b00, 1,   4,    3,     0,  0);
        setv(3,  2'b00, 2'b00, 0,  0,     0,  0,      2'b00, 2'b01, 0,   0,    0,     0,  0);
        setv(4,  2'b10, 2'b00, 0,  0,     0,  0,      2'b00, 2'b00, 0,   0,    0,     0,  0);
        setv(5,  2'b10, 2'b00, 0,  0,     0,  0,      2'b10, 2'b00, 0,   0,    0,     0,  0);
        setv(6,  2'b00, 2'b00, 0,  0,     0,  0,      2'b00, 2'b10, 0,   0,    0,     0,  32'hA5A5_0001);
        setv(7,  2'b11, 2'b10, 4,  0,     8,  32'h77, 2'b00, 2'b00, 0,   0,    0,     0,  32'hA5A5_0001);
        setv(8,  2'b11, 2'b10, 4,  0,     8,  32'h77, 2'b01, 2'b00, 0,   4,    0,     0,  32'hA5A5_0001);
        setv(9,  2'b10, 2'b10, 0,  0,     8,  32'h77, 2'b00, 2'b01, 0,   0,    0,     3,  32'hA5A5_0001);
        setv(10, 2'b10, 2'b10, 0,  0,     8,  32'h77, 2'b00, 2'b00, 0,   0,    0,     3,  32'hA5A5_0001);
        setv(11, 2'b10, 2'b10, 0,  0,     8,  32'h77, 2'b10, 2'b00, 1,   8,    32'h77, 3, 32'hA5A5_0001);
        setv(12, 2'b00, 2'b00, 0,  0,     0,  0,      2'b00, 2'b10, 0,   0,    0,     3,  32'hA5A5_0001);
        setv(13, 2'b00, 2'b00, 0,  0,     0,  0,      2'b00, 2'b00, 0,   0,    0,     3,  32'hA5A5_0001);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        mcheck = 1'b1;

        // Directed vectors: reset state, single write, single read, tie
        for (int i = 0; i < 14; i++) begin
            drv(tbl[i].req, tbl[i].we, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1);
            @(negedge clk);
            chk($sformatf("row%0d gnt", i), {30'd0, m1_gnt_o, m0_gnt_o}, {30'd0, tbl[i].gnt});
            chk($sformatf("row%0d ack", i), {30'd0, m1_ack_o, m0_ack_o}, {30'd0, tbl[i].ack});
            chk($sformatf("row%0d s_we", i), {31'd0, s_we_o}, {31'd0, tbl[i].swe});
            chk($sformatf("row%0d s_addr", i), s_addr_o, tbl[i].saddr);
            chk($sformatf("row%0d s_data", i), s_data_o, tbl[i].sdata);
            chk($sformatf("row%0d m0_data", i), m0_data_o, tbl[i].q0);
            chk($sformatf("row%0d m1_data", i), m1_data_o, tbl[i].q1);
            end_cycle();
        end
        chk("slave reg 0x4", mem[1], 32'h3);
        chk("slave reg 0x8", mem[2], 32'h77);

        // Reset during ACCESS: no ack, outputs cleared, next tie goes to m0
        drv(2'b01, 2'b01, 32'hC, 32'h55, 0, 0);
        @(negedge clk); end_cycle();
        @(negedge clk); chk("rstseq m0 write gnt", {31'd0, m0_gnt_o}, 1); end_cycle();
        drv(2'b00, 2'b00, 0, 0, 0, 0);
        @(negedge clk); chk("rstseq m0 write ack", {31'd0, m0_ack_o}, 1); end_cycle();
        drv(2'b11, 2'b00, 0, 0, 0, 0);
        @(negedge clk); end_cycle();
        rst = 1'b0;
        @(negedge clk); chk("rstseq tie to m1", {30'd0, m1_gnt_o, m0_gnt_o}, 2); end_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("rstseq gnt after reset", {30'd0, m1_gnt_o, m0_gnt_o}, 0);
        chk("rstseq ack after reset", {30'd0, m1_ack_o, m0_ack_o}, 0);
        chk("rstseq s_we after reset", {31'd0, s_we_o}, 0);
        chk("rstseq s_addr after reset", s_addr_o, 0);
        chk("rstseq m0_data after reset", m0_data_o, 0);
        chk("rstseq m1_data after reset", m1_data_o, 0);
        end_cycle();
        @(negedge clk); chk("rstseq tie to m0", {30'd0, m1_gnt_o, m0_gnt_o}, 1); end_cycle();
        drv(2'b00, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        chk("rstseq m0 read ack", {30'd0, m1_ack_o, m0_ack_o}, 1);
        chk("rstseq m0 read data", m0_data_o, 32'hA5A5_0001);
        chk("rstseq m1 data stays 0", m1_data_o, 0);
        chk("slave reg 0xC", mem[3], 32'h55);
        end_cycle();

        // Held request: m0 keeps req high through ACK, back-to-back writes
        exp_we  = '{0, 1, 0, 0, 1, 0};
        exp_ack = '{0, 0, 1, 0, 0, 1};
        for (int i = 0; i < 6; i++) begin
            a0v = 32'h10;
            d0v = (i < 3) ? 32'h1111 : 32'h2222;
            drv((i == 5) ? 2'b00 : 2'b01, 2'b01, a0v, d0v, 0, 0);
            @(negedge clk);
            chk($sformatf("held c%0d s_we", i), {31'd0, s_we_o}, {31'd0, exp_we[i]});
            chk($sformatf("held c%0d ack", i), {31'd0, m0_ack_o}, {31'd0, exp_ack[i]});
            end_cycle();
        end
        chk("held final slave reg", mem[4], 32'h2222);

        // Continuous contention: grants must alternate
        rr_exp = '{1, 0, 1, 0};
        for (int i = 0; i < 12; i++) begin
            drv((i == 11) ? 2'b00 : 2'b11, 2'b00, 0, 0, 32'h4, 0);
            @(negedge clk);
            if (m0_gnt_o) gq.push_back(0);
            if (m1_gnt_o) gq.push_back(1);
            end_cycle();
        end
        chk("rr grant count", 32'(gq.size()), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < gq.size()) chk($sformatf("rr grant %0d", k), 32'(gq[k]), 32'(rr_exp[k]));
        end

        // Randomised traffic against the reference model
        drv(2'b00, 2'b00, 0, 0, 0, 0);
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 59) != 0);
            for (int m = 0; m < 2; m++) begin
                if (req[m] && age == 2 && own == m[0]) begin
                    if ($urandom_range(0, 1) == 1) req[m] = 1'b0;
                    else new_txn(m);
                end else if (!req[m] && $urandom_range(0, 9) < 4) begin
                    new_txn(m);
                end
            end
            @(negedge clk);
            end_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
